// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and parameter legality.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package pipe_adder_pkg;

    // Width of the carry-rippled chunk that each pipeline stage adds.
    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // A legal configuration splits WIDTH into STAGES equal, non-empty chunks.
    function automatic bit params_ok(input int width, input int stages);
        if (stages < 1 || width < stages) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// C-bit ripple adder chunk: {cout, sum} = a + b + cin.
// Latency: purely combinational.
// Backpressure: none, the enclosing stage register handles stalls.
module pipe_adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int C = 4
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout
);

    // One extra bit on every operand catches the carry out of the chunk.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder_n.sv
// Handshaked WIDTH-bit add/subtract split into STAGES carry-rippled chunks.
// Latency: beat accepted at edge t is on the outputs after edge t+STAGES-1.
// Backpressure: a stage loads when empty or when its downstream slot frees; in_ready chains combinationally from out_ready.
module pipe_adder_n
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = chunk_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipe_adder_n: WIDTH must be a non-zero multiple of STAGES and STAGES >= 1");
    end

    // Per-stage pipeline contents: low sum bits become final as the beat
    // travels; the operands are carried along so later chunks can be added.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

    stage_t             st  [STAGES];
    stage_t             nxt [STAGES];
    stage_t             in_beat;
    logic [WIDTH-1:0]   b_eff;
    logic [STAGES-1:0]  space;

    assign b_eff = sub ? ~b : b;

    // Operand prep: subtraction is a + ~b + 1, so cin is ignored when sub=1.
    always_comb begin
        in_beat       = '0;
        in_beat.vld   = in_valid;
        in_beat.carry = sub ? 1'b1 : cin;
        in_beat.a     = a;
        in_beat.b     = b_eff;
        in_beat.a_msb = a[WIDTH-1];
        in_beat.b_msb = b_eff[WIDTH-1];
    end

    // Ready chain from the sink back to the source: an empty stage always
    // has room, a full one only if everything downstream moves too.
    always_comb begin
        logic [STAGES-1:0] sp;
        sp = '0;
        sp[STAGES-1] = !st[STAGES-1].vld || out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            sp[i] = !st[i].vld || sp[i+1];
        end
        space = sp;
    end

    assign in_ready = space[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        stage_t         src;
        stage_t         upd;
        logic [C-1:0]   s_sum;
        logic           s_cout;

        if (i == 0) begin : g_head
            assign src = in_beat;
        end else begin : g_body
            assign src = st[i-1];
        end

        pipe_adder_slice #(.C(C)) u_slice (
            .a    (src.a[i*C +: C]),
            .b    (src.b[i*C +: C]),
            .cin  (src.carry),
            .sum  (s_sum),
            .cout (s_cout)
        );

        // Splice this chunk's result in; bubbles load as all-zero.
        always_comb begin
            upd = '0;
            if (src.vld) begin
                upd                 = src;
                upd.sum[i*C +: C]   = s_sum;
                upd.carry           = s_cout;
            end
        end

        assign nxt[i] = upd;
    end

    // Stage registers: load when there is room, otherwise hold unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                st[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (space[i]) begin
                    st[i] <= nxt[i];
                end
            end
        end
    end

    assign out_valid = st[STAGES-1].vld;
    assign sum       = st[STAGES-1].sum;
    assign cout      = st[STAGES-1].carry;
    assign ovf       = (st[STAGES-1].a_msb == st[STAGES-1].b_msb) &&
                       (st[STAGES-1].sum[WIDTH-1] != st[STAGES-1].a_msb);

endmodule

// File: doc/pipe_adder_n.md
# pipe_adder_n

Parametrised, handshaked, multi-stage pipelined adder/subtractor: the next generation of the team's 4-bit registered pipeline adder. Splits a WIDTH-bit add into STAGES equal carry-rippled chunks, one per register stage, to raise the usable clock rate for wide operands. Sits between a valid/ready operand source and a valid/ready result sink, and tolerates back-pressure without losing or duplicating results.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of STAGES.
- STAGES, 4: number of register stages, ≥1; chunk width C = WIDTH/STAGES.
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0 = a+b+cin, 1 = a−b (a+~b+1).
- out_valid  out  1  result beat present.
- out_ready  in  1  sink accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Operand prep on accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (1..STAGES) register holds: valid_k; sum bits [k·C−1:0] final; carry into chunk k; unconsumed upper bits of a and b_eff; sign bits a[MSB], b_eff[MSB] carried to the last stage for ovf.
- Chunk 0 is added combinationally from inputs and captured into stage 1; chunk k is added from stage k and captured into stage k+1.
- Final stage drives sum, cout; ovf = (a_msb == b_eff_msb) && (sum[MSB] != a_msb).
- Flow control per stage: adv_STAGES = out_ready || !valid_STAGES; adv_k = adv_{k+1} || !valid_{k+1}... specifically stage k loads when !valid_k || adv_k's downstream slot frees; in_ready = !valid_1 || (stage 1 moves forward this cycle). Bubbles collapse: an empty stage always accepts.
- Stage holds its contents unchanged while stalled; data of an invalid stage is don't-care but kept deterministic (zero after reset).
- Accepted beats emerge in order, exactly once.
- Handshake rules: out_valid, once high, stays high with sum/cout/ovf stable until out_ready sampled high. in_ready may depend combinationally on out_ready (ready chain through all stages); in_valid must not depend on in_ready.
- Wrap: results are modulo 2^WIDTH; cout/ovf report the lost bit and signed overflow.

## Timing
- Latency: beat accepted at edge t appears on outputs after edge t+STAGES−1 (out_valid high in the cycle following that edge); STAGES=1 gives one-cycle registered adder.
- Throughput: one beat per cycle when out_ready held high.
- Reset (rst low at rising edge): all valid_k = 0, all stage registers 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in the first cycle after reset release. Reset mid-flight discards all in-flight beats; no partial output.
- Simultaneous accept and output in a full pipeline with out_ready=1: allowed, no bubble.
- Full pipeline with out_ready=0: in_ready=0 until a slot frees.

## Structure
- Shared package pipe_adder_pkg: localparam helpers (chunk width function, parameter legality check) and a stage struct typedef parameterised via WIDTH (valid, partial sum, carry, remaining operands, sign bits).
- One sub-module: pipe_adder_slice (C-bit adder: a, b, cin → sum, cout), instantiated STAGES times in a generate loop.
- Elaboration-time assertion: WIDTH % STAGES == 0, STAGES ≥ 1.

## Test plan
- Reset: hold rst low 3 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0; first beat after release accepted, output after STAGES cycles.
- Streaming, WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, exactly 4 cycles later; back-to-back beats one per cycle.
- Subtract: a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1; a=0x0001, b=0x0002, sub=1 → sum=0xFFFF, cout=0, ovf=0.
- Back-pressure: stream 8 beats, drop out_ready for 5 cycles mid-stream → outputs stable while stalled, in_ready falls after pipeline fills, all 8 results in order, none lost/duplicated.
- Carry across every chunk boundary: a=0x0FFF, b=0x0001, cin=1 → sum=0x1001, cout=0; random 10k beats with random in_valid/out_ready vs. reference model.
- Reset mid-flight: assert rst with 3 beats in pipeline → no stale beat emerges after release; STAGES=1 and WIDTH=32/STAGES=8 configurations re-run the streaming test.
